instr_fetch_unit: RTL and testbench

Upstream fetch stage for the 8-bit, 4-register pipeline core.
- Owns the PC and issues reads to a synchronous instruction memory.
- Buffers returned instructions in a small prefetch FIFO.
- Presents instructions with a valid/ready handshake to the decode stage (the IF/ID boundary).
- Supports a redirect (flush plus new PC) so later control-flow additions can steer fetch.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 tb/tb_instr_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage.
// Opcode field, HALT encoding and the fetch entry bundle.
package fetch_pkg;

  localparam int INSTR_W = 8;
  localparam int PC_W    = 4;
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 6;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic is_halt(
    input logic [INSTR_W-1:0] i
  );
    return i[OP_MSB:OP_LSB] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between instruction memory and decode.
// Clear wins over push; pop of an empty FIFO is ignored.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 12,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_clear,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = i_pop & (r_count != '0);
  assign w_push = i_push & (r_count != CW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= r_wr + PW'(1);
      end
      if (w_pop)
        r_rd <= r_rd + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: PC, imem requests, prefetch FIFO, redirect.
// Optional HALT stop enabled by HALT_DETECT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int AW       = 4,
  parameter int IW       = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0,
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [IW-1:0] instr_out,
  output logic [AW-1:0] instr_pc,
  input  logic          redir_valid,
  input  logic [AW-1:0] redir_pc,
  output logic [CW-1:0] fifo_count,
  output logic          halted
);

  logic [AW-1:0]    r_pc;
  logic [AW-1:0]    r_tag_pc;
  logic             r_inflight;
  logic             r_discard;
  logic             w_req;
  logic             w_push;
  logic             w_pop;
  logic             w_halt_hit;
  logic             w_halted;
  logic [CW:0]      w_load;
  logic [AW+IW-1:0] w_head;

  // Occupancy plus the outstanding word must leave a slot free.
  assign w_load = {1'b0, fifo_count} + {{CW{1'b0}}, r_inflight};
  assign w_req  = ~rst & ~w_halted & ~redir_valid
                & (w_load < (CW+1)'(DEPTH));
  assign w_push = r_inflight & ~r_discard;
  assign w_pop  = instr_valid & instr_ready;

`ifdef HALT_DETECT_EN
  logic r_halted;

  assign w_halt_hit = w_push & ~redir_valid
                    & is_halt(imem_rdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_halted <= 1'b0;
    else if (redir_valid)
      r_halted <= 1'b0;
    else if (w_halt_hit)
      r_halted <= 1'b1;
  end

  assign w_halted = r_halted;
`else
  assign w_halt_hit = 1'b0;
  assign w_halted   = 1'b0;
`endif

  // A HALT also drops the word fetched right behind it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= AW'(RESET_PC);
      r_tag_pc   <= '0;
      r_inflight <= 1'b0;
      r_discard  <= 1'b0;
    end else begin
      r_inflight <= w_req;
      r_discard  <= redir_valid | w_halt_hit;
      if (w_req)
        r_tag_pc <= r_pc;
      if (redir_valid)
        r_pc <= redir_pc;
      else if (w_req)
        r_pc <= r_pc + AW'(1);
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (AW + IW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (redir_valid),
    .i_data  ({r_tag_pc, imem_rdata}),
    .o_head  (w_head),
    .o_count (fifo_count)
  );

  assign imem_req    = w_req;
  assign imem_addr   = r_pc;
  assign instr_valid = (fifo_count != '0);
  assign instr_pc    = w_head[AW+IW-1:IW];
  assign instr_out   = w_head[IW-1:0];
  assign halted      = w_halted;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit.
// Queue-level reference model plus literal pins.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic [7:0] imem_rdata = '0;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [7:0] instr_out;
  logic [3:0] instr_pc;
  logic       redir_valid = 1'b0;
  logic [3:0] redir_pc = '0;
  logic [2:0] fifo_count;
  logic       halted;

  logic [7:0] mem [16];

  instr_fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .fifo_count  (fifo_count),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (imem_req) imem_rdata <= mem[imem_addr];

  int vectors = 0;
  int errors  = 0;
  int cyc;
  int first_valid;

  fetch_entry_t mq[$];
  fetch_entry_t got[$];
  logic [3:0]   m_pc;
  logic [3:0]   m_pend_pc;
  bit           m_pend;
  bit           m_drop;
  bit           m_halted;

  task automatic chk(input string n, input int a, input int e);
    vectors++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               n, a, e, cyc);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_pc      = 4'h0;
    m_pend_pc = 4'h0;
    m_pend    = 0;
    m_drop    = 0;
    m_halted  = 0;
  endfunction

  function automatic void model_edge(
    input bit r, input bit v, input logic [3:0] p
  );
    bit req;
    bit kill;
    fetch_entry_t e;
    req  = !m_halted && !v
        && (mq.size() + int'(m_pend) < DEPTH);
    kill = 0;
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (v) begin
      mq.delete();
      m_pc     = p;
      m_halted = 0;
      m_pend   = 0;
      m_drop   = 1;
    end else begin
      if (m_pend && !m_drop) begin
        e.pc    = m_pend_pc;
        e.instr = mem[m_pend_pc];
        mq.push_back(e);
`ifdef HALT_DETECT_EN
        if (e.instr[7:6] == 2'b11) begin
          m_halted = 1;
          kill     = 1;
        end
`endif
      end
      m_pend = req;
      if (req) begin
        m_pend_pc = m_pc;
        m_pc      = m_pc + 4'h1;
      end
      m_drop = kill;
    end
  endfunction

  task automatic check_all();
    bit exp_req;
    fetch_entry_t e;
    exp_req = !m_halted && !redir_valid
           && (mq.size() + int'(m_pend) < DEPTH);
    chk("imem_req", int'(imem_req), int'(exp_req));
    chk("imem_addr", int'(imem_addr), int'(m_pc));
    chk("instr_valid", int'(instr_valid), int'(mq.size() != 0));
    chk("fifo_count", int'(fifo_count), mq.size());
    chk("halted", int'(halted), int'(m_halted));
    if (mq.size() != 0) begin
      chk("instr_out", int'(instr_out), int'(mq[0].instr));
      chk("instr_pc", int'(instr_pc), int'(mq[0].pc));
    end
    if (instr_valid && first_valid < 0) first_valid = cyc;
    if (instr_valid && instr_ready) begin
      e.pc    = instr_pc;
      e.instr = instr_out;
      got.push_back(e);
    end
  endtask

  task automatic step(
    input bit r, input bit v, input logic [3:0] p
  );
    instr_ready = r;
    redir_valid = v;
    redir_pc    = p;
    #1;
    check_all();
    model_edge(r, v, p);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    instr_ready = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    model_reset();
    got.delete();
    @(negedge clk);
    #1;
    chk("rst imem_req", int'(imem_req), 0);
    chk("rst instr_valid", int'(instr_valid), 0);
    chk("rst fifo_count", int'(fifo_count), 0);
    chk("rst instr_out", int'(instr_out), 0);
    chk("rst instr_pc", int'(instr_pc), 0);
    @(negedge clk);
    rst         = 1'b0;
    cyc         = 0;
    first_valid = -1;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 16; i++)
      mem[i] = 8'($urandom_range(0, 191));
    mem[0] = 8'h05;
    mem[1] = 8'h5A;
    mem[2] = 8'h81;
    mem[3] = 8'h1B;
  endtask

  initial begin
    cyc = 0;
    first_valid = -1;
    load_mem();

    // streaming from reset
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 0);
    chk("latency", first_valid, 2);
    chk("s0 instr", int'(got[0].instr), 'h05);
    chk("s1 instr", int'(got[1].instr), 'h5A);
    chk("s2 instr", int'(got[2].instr), 'h81);
    chk("s3 instr", int'(got[3].instr), 'h1B);
    chk("s3 pc", int'(got[3].pc), 3);
    chk("stream len", got.size(), 6);

    // backpressure then drain
    do_reset();
    for (int i = 0; i < 10; i++) step(0, 0, 0);
    #1;
    chk("bp count", int'(fifo_count), 4);
    chk("bp req", int'(imem_req), 0);
    chk("bp head", int'(instr_out), 'h05);
    chk("bp head pc", int'(instr_pc), 0);
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    for (int i = 0; i < got.size(); i++)
      chk("drain pc", int'(got[i].pc), i % 16);
    chk("drain 2", int'(got[2].instr), 'h81);

    // redirect with 3 entries and one in flight
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    #1;
    chk("pre redir count", int'(fifo_count), 3);
    step(0, 1, 4'hA);
    #1;
    chk("post redir count", int'(fifo_count), 0);
    got.delete();
    for (int i = 0; i < 6; i++) step(1, 0, 0);
    chk("redir first pc", int'(got[0].pc), 'hA);
    chk("redir first instr", int'(got[0].instr), int'(mem[10]));

    // PC wrap
    step(1, 1, 4'hE);
    got.delete();
    for (int i = 0; i < 7; i++) step(1, 0, 0);
    chk("wrap pc0", int'(got[0].pc), 'hE);
    chk("wrap pc1", int'(got[1].pc), 'hF);
    chk("wrap pc2", int'(got[2].pc), 'h0);
    chk("wrap pc3", int'(got[3].pc), 'h1);

    // HALT opcode at address 2
    mem[2] = 8'hC0;
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 0, 0);
    chk("halt word", int'(got[2].instr), 'hC0);
`ifdef HALT_DETECT_EN
    chk("halt len", got.size(), 3);
    chk("halted", int'(halted), 1);
`else
    chk("no halt len", got.size(), 8);
    chk("not halted", int'(halted), 0);
`endif
    step(1, 1, 4'h0);
    got.delete();
    for (int i = 0; i < 4; i++) step(1, 0, 0);
    chk("refetch pc", int'(got[0].pc), 0);
    chk("refetch halted", int'(halted), 0);
    mem[2] = 8'h81;

    // async reset mid-stream
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    #1;
    chk("pre arst count", int'(fifo_count), 3);
    #1;
    rst = 1'b1;
    #1;
    chk("arst valid", int'(instr_valid), 0);
    chk("arst count", int'(fifo_count), 0);
    chk("arst req", int'(imem_req), 0);
    model_reset();
    got.delete();
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    chk("arst restart pc", int'(got[0].pc), 0);
    chk("arst restart instr", int'(got[0].instr), 'h05);

    // randomized traffic
    for (int i = 0; i < 16; i++)
      mem[i] = 8'($urandom);
    do_reset();
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0,
           4'($urandom));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
